sata_dma_sched: RTL and testbench
=================================

# sata_dma_sched

Two-requester scheduler in front of the SATA DMA engine's single command interface (`dma_req`/`dma_ack`, address, length, direction, sof/eof). It round-robin arbitrates between the command-side requester (port 0: command FIS / PRD fetch) and the data-side requester (port 1: data FIS payload). It splits each granted transfer into chunks no longer than `C_MAX_CHUNK` bytes and marks the first and last chunks with `dma_sof`/`dma_eof`. It reports completion or abort back to the owning requester.

## Interface

Parameters:
- `C_MAX_CHUNK`, default 512: maximum bytes per `dma_req`; must be a power of 2, 4..4096.
- `C_ADDR_W`, default 32: address width.

Ports:
- `sys_clk`  in  1  single clock for the whole block.
- `sys_rst_n`  in  1  reset; asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  transfer request level. Held high until the matching `reqN_done`.
- `req0_addr` / `req1_addr`  in  C_ADDR_W  byte start address. Sampled at grant.
- `req0_len` / `req1_len`  in  16  byte count. Sampled at grant.
- `req0_wrt` / `req1_wrt`  in  1  direction: 1 = memory write, 0 = memory read. Sampled at grant.
- `reqN_done`  out  1  one-cycle completion pulse to port N.
- `reqN_aborted`  out  1  qualifies `reqN_done`: the transfer was cut short.
- `abort`  in  1  level; terminates the active transfer at the next chunk boundary.
- `dma_req`  out  1  chunk request to the DMA engine.
- `dma_ack`  in  1  one-cycle pulse accepting the chunk.
- `dma_address`  out  C_ADDR_W  chunk start address.
- `dma_length`  out  16  chunk byte count.
- `dma_wrt`  out  1  chunk direction.
- `dma_sof`  out  1  chunk is the first of its transfer.
- `dma_eof`  out  1  chunk is the last of its transfer.
- `busy`  out  1  FSM is not in IDLE.
- `grant_id`  out  1  port that owns the current transfer.

## Operation

States: IDLE, ISSUE, NEXT, DONE.

- **IDLE**
  - If any `reqN_valid` is high, grant a port. Both requesting: grant the port not served last. One requesting: grant that port.
  - Latch address, length and direction into `cur_addr`, `remain` and `cur_wrt`. Set `first = 1`.
  - Length 0: go straight to DONE with `aborted = 0` and issue no `dma_req`.
  - Otherwise go to ISSUE.
- **Chunk size:** `chunk = min(remain, C_MAX_CHUNK, bdry)`, where `bdry` is defined under Configuration.
- **ISSUE**
  - Drive `dma_req = 1` with `dma_address = cur_addr`, `dma_length = chunk`, `dma_sof = first`, `dma_eof = (chunk == remain)`.
  - All these outputs stay stable until `dma_ack`.
  - On `dma_ack`: drop `dma_req` in the same edge; `cur_addr += chunk`; `remain -= chunk`; `first = 0`.
  - If the new `remain == 0`, go to DONE with `aborted = 0`.
  - Else if `abort` is high, go to DONE with `aborted = 1`.
  - Else go to NEXT.
- **NEXT:** one bubble cycle to recompute `chunk`, then ISSUE.
- **DONE:** pulse `reqN_done` (and `reqN_aborted` if set) for the granted port. Update `last_grant`. Return to IDLE.
- **Abort timing:** `abort` never withdraws a `dma_req` that is already asserted.
  - Abort seen in NEXT: go to DONE with `aborted = 1`.
  - Abort high in IDLE: blocks new grants.
- **Requester side:** a requester must deassert `reqN_valid` the cycle after `reqN_done`. The IDLE cycle that follows DONE prevents a re-grant on a stale `valid`.
- **Address arithmetic:** modulo 2^C_ADDR_W; wrap is allowed and not flagged.
- **Alignment:** `addr[1:0]` and `len[1:0]` are assumed 0 by the requesters; the block does not check them.

## Timing

- Reset values:
  - All outputs 0.
  - State IDLE.
  - `last_grant = 1`, so port 0 wins the first tie.
- Grant latency: `reqN_valid` high in IDLE → `dma_req` high in the 2nd cycle (registered, via the grant edge).
- Chunk cadence:
  - `dma_ack` → next `dma_req` after 2 cycles (NEXT bubble).
  - `dma_ack` on the final chunk → `reqN_done` 1 cycle later.
- `dma_ack` while `dma_req` is low is ignored.
- Reset asserted mid-transfer: every output clears asynchronously. Neither requester receives `done`.

## Configuration

- `SATA_DMA_SCHED_4K_BOUNDARY_EN`
  - Defined: `bdry = 4096 - cur_addr[11:0]`, so no chunk crosses a 4 KiB address boundary (MPMC page rule).
  - Undefined: `bdry = 65535`, so chunks are limited only by `C_MAX_CHUNK` and `remain`.

## Structure

- Shared package `sata_dma_sched_pkg` holds:
  - the state enum (IDLE, ISSUE, NEXT, DONE);
  - port index constants `PORT_CMD = 0`, `PORT_DATA = 1`;
  - the 4 KiB page constant.
- One sub-module, `sata_dma_chunk_calc`: combinational min of `remain`, `C_MAX_CHUNK` and the boundary term, instantiated once.
- Arbiter, FSM and counters live in the top level.

## Test plan

- **Single request, one chunk:** port 0, addr 0x1000, len 256 → one `dma_req` with len 256, sof = 1, eof = 1; `req0_done` 1 cycle after ack; `aborted` = 0.
- **Split transfer:** port 1, addr 0x2000, len 1300, `C_MAX_CHUNK` = 512 → chunks 512/512/276 at 0x2000/0x2200/0x2400; sof only on the first, eof only on the last.
- **Boundary split (macro defined):** addr 0x0F80, len 512 → chunks 128 @ 0x0F80 and 384 @ 0x1000. With the macro undefined: a single 512-byte chunk.
- **Arbitration:**
  - Both valid from reset → port 0 served first, then port 1.
  - Then both valid again → port 0 is served next, because port 1 was served last.
- **Abort and zero length:**
  - len 2048 with `abort` raised during the second chunk → second chunk completes; `req_done` with `aborted` = 1; exactly 2 `dma_req`.
  - len 0 → `done` with no `dma_req`.
- **Reset mid-transfer:** `sys_rst_n` low while `dma_req` = 1 → all outputs 0 immediately; after release, the next grant goes to port 0.

Source files
------------

// File: rtl/sata_dma_sched_pkg.sv
// Shared types and constants for the SATA DMA two-port chunking scheduler.
package sata_dma_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StNext,
    StDone
  } state_e;

  localparam logic PORT_CMD  = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam int unsigned PAGE_BYTES = 4096;

endpackage

// File: rtl/sata_dma_chunk_calc.sv
// Chunk size = min(remain, C_MAX_CHUNK, bytes to next 4 KiB page).
// Page limiting is enabled by defining SATA_DMA_SCHED_4K_BOUNDARY_EN.
module sata_dma_chunk_calc
  import sata_dma_sched_pkg::*;
#(
  parameter int unsigned C_MAX_CHUNK = 512
) (
  input  logic [15:0] remain,
  input  logic [11:0] page_off,
  output logic [15:0] chunk
);

  localparam logic [15:0] MaxChunk = 16'(C_MAX_CHUNK);

  logic [15:0] bdry;
  logic [15:0] capped;

`ifdef SATA_DMA_SCHED_4K_BOUNDARY_EN
  assign bdry = 16'(PAGE_BYTES) - {4'd0, page_off};
`else
  logic unused_page_off;
  assign unused_page_off = ^page_off;
  assign bdry = 16'hFFFF;
`endif

  assign capped = (remain < MaxChunk) ? remain : MaxChunk;
  assign chunk  = (capped < bdry) ? capped : bdry;

endmodule

// File: rtl/sata_dma_sched.sv
// Round-robin two-port scheduler that splits transfers into DMA chunks.
// Optional 4 KiB page splitting: define SATA_DMA_SCHED_4K_BOUNDARY_EN.
module sata_dma_sched
  import sata_dma_sched_pkg::*;
#(
  parameter int unsigned C_MAX_CHUNK = 512,
  parameter int unsigned C_ADDR_W    = 32
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                req0_valid,
  input  logic [C_ADDR_W-1:0] req0_addr,
  input  logic [15:0]         req0_len,
  input  logic                req0_wrt,
  output logic                req0_done,
  output logic                req0_aborted,
  input  logic                req1_valid,
  input  logic [C_ADDR_W-1:0] req1_addr,
  input  logic [15:0]         req1_len,
  input  logic                req1_wrt,
  output logic                req1_done,
  output logic                req1_aborted,
  input  logic                abort,
  output logic                dma_req,
  input  logic                dma_ack,
  output logic [C_ADDR_W-1:0] dma_address,
  output logic [15:0]         dma_length,
  output logic                dma_wrt,
  output logic                dma_sof,
  output logic                dma_eof,
  output logic                busy,
  output logic                grant_id
);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                cur_wrt_q, cur_wrt_d;
  logic                first_q, first_d;
  logic                aborted_q, aborted_d;
  logic [C_ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [15:0]         remain_q, remain_d;
  logic [15:0]         chunk;
  logic                issue;

  sata_dma_chunk_calc #(
    .C_MAX_CHUNK(C_MAX_CHUNK)
  ) u_chunk_calc (
    .remain  (remain_q),
    .page_off(cur_addr_q[11:0]),
    .chunk   (chunk)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      grant_q      <= PORT_CMD;
      last_grant_q <= PORT_DATA;  // port 0 wins the first tie
      cur_wrt_q    <= 1'b0;
      first_q      <= 1'b0;
      aborted_q    <= 1'b0;
      cur_addr_q   <= '0;
      remain_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cur_wrt_q    <= cur_wrt_d;
      first_q      <= first_d;
      aborted_q    <= aborted_d;
      cur_addr_q   <= cur_addr_d;
      remain_q     <= remain_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cur_wrt_d    = cur_wrt_q;
    first_d      = first_q;
    aborted_d    = aborted_q;
    cur_addr_d   = cur_addr_q;
    remain_d     = remain_q;
    unique case (state_q)
      StIdle: begin
        if (!abort && (req0_valid || req1_valid)) begin
          if (req0_valid && req1_valid) grant_d = ~last_grant_q;
          else                          grant_d = req1_valid ? PORT_DATA : PORT_CMD;
          cur_addr_d = grant_d ? req1_addr : req0_addr;
          remain_d   = grant_d ? req1_len : req0_len;
          cur_wrt_d  = grant_d ? req1_wrt : req0_wrt;
          first_d    = 1'b1;
          aborted_d  = 1'b0;
          state_d    = (remain_d == 16'd0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (dma_ack) begin
          cur_addr_d = cur_addr_q + C_ADDR_W'(chunk);
          remain_d   = remain_q - chunk;
          first_d    = 1'b0;
          if (remain_d == 16'd0) begin
            aborted_d = 1'b0;
            state_d   = StDone;
          end else if (abort) begin
            aborted_d = 1'b1;
            state_d   = StDone;
          end else begin
            state_d   = StNext;
          end
        end
      end
      StNext: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else begin
          state_d   = StIssue;
        end
      end
      StDone: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Chunk outputs are gated so they read zero outside ISSUE (incl. reset).
  always_comb begin
    issue        = (state_q == StIssue);
    dma_req      = issue;
    dma_address  = issue ? cur_addr_q : '0;
    dma_length   = issue ? chunk : 16'd0;
    dma_wrt      = issue & cur_wrt_q;
    dma_sof      = issue & first_q;
    dma_eof      = issue & (chunk == remain_q);
    busy         = (state_q != StIdle);
    grant_id     = grant_q;
    req0_done    = (state_q == StDone) && (grant_q == PORT_CMD);
    req1_done    = (state_q == StDone) && (grant_q == PORT_DATA);
    req0_aborted = req0_done & aborted_q;
    req1_aborted = req1_done & aborted_q;
  end

endmodule

// File: tb/tb_sata_dma_sched.sv
// Scoreboard bench for sata_dma_sched: stimulus queues expected chunks/dones, monitor checks.
module tb_sata_dma_sched;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_addr = '0, req1_addr = '0;
  logic [15:0] req0_len = '0, req1_len = '0;
  logic        req0_wrt = 1'b0, req1_wrt = 1'b0;
  logic        req0_done, req0_aborted, req1_done, req1_aborted;
  logic        abort = 1'b0;
  logic        dma_req;
  logic        dma_ack = 1'b0;
  logic [31:0] dma_address;
  logic [15:0] dma_length;
  logic        dma_wrt, dma_sof, dma_eof, busy, grant_id;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic        wrt;
    logic        sof;
    logic        eof;
  } chunk_t;

  typedef struct packed {
    logic port;
    logic aborted;
  } done_t;

  chunk_t exp_chunks[$];
  done_t  exp_dones[$];
  int     checks = 0;
  int     errors = 0;
  int     n_chunks = 0;
  logic   ack_block = 1'b0;

  sata_dma_sched #(
    .C_MAX_CHUNK(512),
    .C_ADDR_W   (32)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req0_valid  (req0_valid),
    .req0_addr   (req0_addr),
    .req0_len    (req0_len),
    .req0_wrt    (req0_wrt),
    .req0_done   (req0_done),
    .req0_aborted(req0_aborted),
    .req1_valid  (req1_valid),
    .req1_addr   (req1_addr),
    .req1_len    (req1_len),
    .req1_wrt    (req1_wrt),
    .req1_done   (req1_done),
    .req1_aborted(req1_aborted),
    .abort       (abort),
    .dma_req     (dma_req),
    .dma_ack     (dma_ack),
    .dma_address (dma_address),
    .dma_length  (dma_length),
    .dma_wrt     (dma_wrt),
    .dma_sof     (dma_sof),
    .dma_eof     (dma_eof),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // DMA engine model: one-cycle ack pulse right after each presented chunk.
  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (dma_ack) dma_ack = 1'b0;
      else if (dma_req && !ack_block) dma_ack = 1'b1;
    end
  end

  always @(negedge sys_clk) begin
    chunk_t got;
    done_t  gd;
    if (sys_rst_n) begin
      if (dma_req && dma_ack) begin
        got = {dma_address, dma_length, dma_wrt, dma_sof, dma_eof};
        n_chunks++;
        if (exp_chunks.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected chunk: got %0h expected none", got);
        end else begin
          chk("chunk", 64'(got), 64'(exp_chunks.pop_front()));
        end
      end
      if (req0_done || req1_done || req0_aborted || req1_aborted) begin
        gd = {req1_done, req1_done ? req1_aborted : req0_aborted};
        if (exp_dones.size() == 0 || (req0_done && req1_done)) begin
          checks++;
          errors++;
          $display("FAIL unexpected done: got %0b%0b%0b%0b expected none",
                   req0_done, req0_aborted, req1_done, req1_aborted);
        end else begin
          chk("done", 64'(gd), 64'(exp_dones.pop_front()));
        end
      end
    end
  end

  task automatic push_chunk(input logic [31:0] a, input logic [15:0] l,
                            input logic w, input logic s, input logic e);
    exp_chunks.push_back({a, l, w, s, e});
  endtask

  task automatic push_done(input logic p, input logic ab);
    exp_dones.push_back({p, ab});
  endtask

  task automatic req(input logic p, input logic [31:0] a, input logic [15:0] l, input logic w);
    if (p) begin
      req1_addr = a; req1_len = l; req1_wrt = w; req1_valid = 1'b1;
    end else begin
      req0_addr = a; req0_len = l; req0_wrt = w; req0_valid = 1'b1;
    end
  endtask

  // Requester model: drop valid once its done pulse is seen.
  task automatic drain(input int budget);
    int n = 0;
    while ((req0_valid || req1_valid) && n < budget) begin
      @(negedge sys_clk);
      if (req0_done) req0_valid = 1'b0;
      if (req1_done) req1_valid = 1'b0;
      n++;
    end
    checks++;
    if (req0_valid || req1_valid) begin
      errors++;
      $display("FAIL drain timeout: valids %0b%0b still pending", req0_valid, req1_valid);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    repeat (2) @(negedge sys_clk);
  endtask

  function automatic logic [63:0] outs();
    return 64'({dma_req, dma_address, dma_length, dma_wrt, dma_sof, dma_eof, busy, grant_id,
                req0_done, req0_aborted, req1_done, req1_aborted});
  endfunction

  initial begin
    int base;
    int n;
    repeat (3) @(negedge sys_clk);
    chk("reset outputs", outs(), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Arbitration from reset: port 0 first, then port 1; again port 0 first.
    push_chunk(32'h100, 16'd64, 1'b1, 1'b1, 1'b1); push_done(1'b0, 1'b0);
    push_chunk(32'h200, 16'd32, 1'b0, 1'b1, 1'b1); push_done(1'b1, 1'b0);
    req(1'b0, 32'h100, 16'd64, 1'b1);
    req(1'b1, 32'h200, 16'd32, 1'b0);
    drain(200);
    push_chunk(32'h300, 16'd16, 1'b0, 1'b1, 1'b1); push_done(1'b0, 1'b0);
    push_chunk(32'h400, 16'd8, 1'b1, 1'b1, 1'b1);  push_done(1'b1, 1'b0);
    req(1'b0, 32'h300, 16'd16, 1'b0);
    req(1'b1, 32'h400, 16'd8, 1'b1);
    drain(200);

    // Single chunk
    push_chunk(32'h1000, 16'd256, 1'b1, 1'b1, 1'b1); push_done(1'b0, 1'b0);
    req(1'b0, 32'h1000, 16'd256, 1'b1);
    drain(200);

    // Split transfer 512/512/276
    push_chunk(32'h2000, 16'd512, 1'b0, 1'b1, 1'b0);
    push_chunk(32'h2200, 16'd512, 1'b0, 1'b0, 1'b0);
    push_chunk(32'h2400, 16'd276, 1'b0, 1'b0, 1'b1);
    push_done(1'b1, 1'b0);
    req(1'b1, 32'h2000, 16'd1300, 1'b0);
    drain(300);

    // Page boundary
`ifdef SATA_DMA_SCHED_4K_BOUNDARY_EN
    push_chunk(32'h0F80, 16'd128, 1'b1, 1'b1, 1'b0);
    push_chunk(32'h1000, 16'd384, 1'b1, 1'b0, 1'b1);
`else
    push_chunk(32'h0F80, 16'd512, 1'b1, 1'b1, 1'b1);
`endif
    push_done(1'b0, 1'b0);
    req(1'b0, 32'h0F80, 16'd512, 1'b1);
    drain(200);

    // Abort raised during the second chunk
    push_chunk(32'h4000, 16'd512, 1'b1, 1'b1, 1'b0);
    push_chunk(32'h4200, 16'd512, 1'b1, 1'b0, 1'b0);
    push_done(1'b0, 1'b1);
    base = n_chunks;
    req(1'b0, 32'h4000, 16'd2048, 1'b1);
    n = 0;
    while (!(dma_req && n_chunks == base + 1) && n < 100) begin
      @(posedge sys_clk);
      #2;
      n++;
    end
    abort = 1'b1;
    drain(200);
    abort = 1'b0;
    chk("abort chunk count", 64'(n_chunks - base), 64'd2);

    // Zero length: done without any chunk
    push_done(1'b1, 1'b0);
    base = n_chunks;
    req(1'b1, 32'h5000, 16'd0, 1'b0);
    drain(100);
    chk("zero-len chunk count", 64'(n_chunks - base), 64'd0);

    // Reset mid-transfer
    ack_block = 1'b1;
    req(1'b1, 32'h8000, 16'd2048, 1'b0);
    n = 0;
    while (!dma_req && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    chk("dma_req before reset", 64'(dma_req), 64'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("outputs in reset", outs(), 64'd0);
    req1_valid = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    ack_block = 1'b0;
    @(negedge sys_clk);
    push_chunk(32'h500, 16'd4, 1'b1, 1'b1, 1'b1); push_done(1'b0, 1'b0);
    push_chunk(32'h600, 16'd4, 1'b0, 1'b1, 1'b1); push_done(1'b1, 1'b0);
    req(1'b0, 32'h500, 16'd4, 1'b1);
    req(1'b1, 32'h600, 16'd4, 1'b0);
    drain(200);

    chk("chunk queue empty", 64'(exp_chunks.size()), 64'd0);
    chk("done queue empty", 64'(exp_dones.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
